dmem_responder: RTL and testbench

Wait-state data-memory responder serving the load/store side of the single-cycle core when it is moved onto a handshaked bus. It accepts one read or write request at a time and holds it for a programmable number of wait states. It then returns a response with read data and an error flag, and holds that response until the initiator takes it. It is the memory-side end of the core's data interface: the core issues requests and this block services them.

---
 rtl/dmem_responder.sv | 186 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder for the core's load/store
// port. Accepts one request at a time and holds it for WAIT_CYCLES wait states.
// The array is updated (store) or read (load) on the edge that raises
// rsp_valid. The response is then held until the initiator takes it.
//
// Optional feature macro: DMEM_RESP_WSTRB_EN
//   defined   - stores honour req_wstrb byte enables (wstrb = 0 is a no-op)
//   undefined - req_wstrb is ignored and every good store writes the full word
module dmem_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [31:0] DEPTH_32  = 32'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state, state_nxt;

   // wait-state down-counter, meaningful only in ST_WAIT
   logic [3:0]  wait_cnt;

   // latched request; the live request pins are ignored once accepted
   logic        lat_write;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   // backing store; deliberately never cleared
   logic [31:0] mem [DEPTH_WORDS];

   logic        accept;
   logic        rsp_fire;
   logic        commit;

   // request being committed: live pins when committing straight from IDLE
   // (WAIT_CYCLES = 0), otherwise the latched copy
   logic        cur_write;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [31:0] cur_off;
   logic        cur_err;
   logic [IDX_W-1:0] cur_idx;

`ifdef DMEM_RESP_WSTRB_EN
   logic [3:0]  lat_wstrb;
   logic [3:0]  cur_wstrb;
`else
   // strobes are not used in this build; the port stays for stable wiring
   logic        wstrb_unused;
   assign wstrb_unused = ^req_wstrb;
`endif

   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign accept    = (state == ST_IDLE) && req_valid;
   assign rsp_fire  = (state == ST_RESP) && rsp_ready;

   // select the request under commit and decode its address
   always_comb begin
      cur_write = lat_write;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
`ifdef DMEM_RESP_WSTRB_EN
      cur_wstrb = lat_wstrb;
`endif
      if (state == ST_IDLE) begin
         cur_write = req_write;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
`ifdef DMEM_RESP_WSTRB_EN
         cur_wstrb = req_wstrb;
`endif
      end
      // all address arithmetic is 32-bit; the below-base test catches wrap
      cur_off = cur_addr - BASE_ADDR;
      cur_err = (cur_addr[1:0] != 2'b00) |
                (cur_addr < BASE_ADDR) |
                ((cur_off >> 2) >= DEPTH_32);
      cur_idx = cur_off[IDX_W+1:2];
   end

   // next-state logic; commit marks the transition into ST_RESP
   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = ST_RESP;
                  commit    = 1'b1;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt = ST_RESP;
               commit    = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // request latch and wait-state counter
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= 4'd0;
         lat_write <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
`ifdef DMEM_RESP_WSTRB_EN
         lat_wstrb <= 4'd0;
`endif
      end else if (accept) begin
         wait_cnt  <= WAIT_LOAD;
         lat_write <= req_write;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
`ifdef DMEM_RESP_WSTRB_EN
         lat_wstrb <= req_wstrb;
`endif
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // response registers: loaded at commit, held in RESP, cleared on handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (commit) begin
         rsp_err   <= cur_err;
         rsp_rdata <= (!cur_write && !cur_err) ? mem[cur_idx] : 32'd0;
      end else if (rsp_fire) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end
   end

   // array write at commit; reset blocks a store that has not yet committed
   always_ff @(posedge clk) begin
      if (!rst && commit && cur_write && !cur_err) begin
`ifdef DMEM_RESP_WSTRB_EN
         for (int b = 0; b < 4; b++) begin
            if (cur_wstrb[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
         end
`else
         mem[cur_idx] <= cur_wdata;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table on a WAIT_CYCLES=2 instance,
// hand-written reset sequences, then randomized traffic on that instance and
// on a WAIT_CYCLES=0 instance with a non-zero base, checked against a
// word-array reference model.
module tb_dmem_responder;

   localparam int          W0 = 2;
   localparam int          W1 = 0;
   localparam int          D0 = 256;
   localparam int          D1 = 16;
   localparam logic [31:0] B0 = 32'h0000_0000;
   localparam logic [31:0] B1 = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_write [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wstrb [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH_WORDS(D0), .WAIT_CYCLES(W0), .BASE_ADDR(B0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   dmem_responder #(.DEPTH_WORDS(D1), .WAIT_CYCLES(W1), .BASE_ADDR(B1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] mdl   [2][256];
   bit          known [2][256];

   function automatic logic [31:0] base_of(int d);
      return (d == 0) ? B0 : B1;
   endfunction

   function automatic int depth_of(int d);
      return (d == 0) ? D0 : D1;
   endfunction

   function automatic logic m_err(int d, logic [31:0] a);
      logic [63:0] aa, bb;
      aa = {32'd0, a};
      bb = {32'd0, base_of(d)};
      if (aa % 4 != 0) return 1'b1;
      if (aa < bb)     return 1'b1;
      return ((aa - bb) / 4) >= 64'(depth_of(d));
   endfunction

   // apply one request to the model; ok = expected read data is known
   task automatic m_apply(input int d, input logic wr, input logic [31:0] a, wd,
                          input logic [3:0] ws, output logic [31:0] erd,
                          output logic eerr, output bit ok);
      int idx;
      eerr = m_err(d, a);
      erd  = 32'd0;
      ok   = 1'b1;
      if (!eerr) begin
         idx = int'((a - base_of(d)) / 4);
         if (wr) begin
`ifdef DMEM_RESP_WSTRB_EN
            for (int b = 0; b < 4; b++)
               if (ws[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
`else
            mdl[d][idx] = wd;
`endif
            known[d][idx] = 1'b1;
         end else begin
            erd = mdl[d][idx];
            ok  = known[d][idx];
         end
      end
   endtask

   function automatic logic [31:0] gen_addr(int d);
      logic [31:0] b;
      int nw;
      b  = base_of(d);
      nw = (d == 0) ? 32 : 16;
      case ($urandom % 8)
         0, 1, 2, 3, 4: return b + 32'(4 * ($urandom % nw));
         5:             return b + 32'(4 * ($urandom % nw)) + 32'($urandom_range(1, 3));
         6:             return b + 32'(4 * (depth_of(d) + int'($urandom % 8)));
         default:       return (d == 0) ? 32'hFFFF_FFFC : b - 32'(4 * (1 + $urandom % 4));
      endcase
   endfunction

   // ---------------- transaction driver ----------------
   // called at a negedge with the target idle; hold < 0 keeps rsp_ready high
   // from the start, otherwise rsp_ready rises hold cycles after rsp_valid
   task automatic txn(input int d, input logic wr, input logic [31:0] a, wd,
                      input logic [3:0] ws, input int hold,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int acc);
      int n;
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_wstrb[d] = ws;
      rsp_ready[d] = (hold < 0);
      n = 0;
      while (!req_ready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_at_issue", 32'(req_ready[d]), 32'd1);
      acc = cyc;
      @(negedge clk);
      // scribble the request pins: the block must use its latched copy
      req_valid[d] = 1'b0;
      req_write[d] = ~wr;
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      req_wstrb[d] = 4'($urandom);
      lat = 1;
      while (!rsp_valid[d] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd = rsp_rdata[d];
      er = rsp_err[d];
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", 32'(rsp_valid[d]), 32'd1);
         chk("hold_rsp_rdata", rsp_rdata[d], rd);
         chk("hold_rsp_err",   32'(rsp_err[d]), 32'(er));
         chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
      end
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      chk("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("post_req_ready", 32'(req_ready[d]), 32'd1);
      chk("post_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("post_rsp_err",   32'(rsp_err[d]), 32'd0);
      rsp_ready[d] = (hold < 0);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  ws;
      int          hold;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   localparam int NV = 18;
   vec_t vt [NV];

   task automatic check_reset_outs(input int d, input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata[d], 32'd0);
      chk({tag, "_rsp_err"},   32'(rsp_err[d]), 32'd0);
   endtask

   initial begin
      logic [31:0] rd, erd, a, wd;
      logic        er, eerr, wr;
      logic [3:0]  ws;
      int          lat, acc, prev_acc, n, d, hold;
      bit          ok;

      // directed table on dut0 (WAIT_CYCLES=2, base 0, 256 words)
      vt[0]  = '{1'b1, 32'h000, 32'hCAFEF00D, 4'hF,  0, 32'h0, 1'b0};
      vt[1]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF,  0, 32'h0, 1'b0};
      vt[2]  = '{1'b0, 32'h010, 32'h0,        4'hF,  0, 32'hDEADBEEF, 1'b0};
      vt[3]  = '{1'b0, 32'h013, 32'h0,        4'hF,  0, 32'h0, 1'b1};
      vt[4]  = '{1'b1, 32'h400, 32'h12345678, 4'hF,  0, 32'h0, 1'b1};
      vt[5]  = '{1'b0, 32'h000, 32'h0,        4'hF,  5, 32'hCAFEF00D, 1'b0};
      vt[6]  = '{1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF,  0, 32'h0, 1'b0};
      vt[7]  = '{1'b0, 32'h3FC, 32'h0,        4'hF,  1, 32'h0BADCAFE, 1'b0};
      vt[8]  = '{1'b1, 32'h030, 32'h11223344, 4'hF,  0, 32'h0, 1'b0};
      vt[9]  = '{1'b1, 32'h030, 32'hAABBCCDD, 4'h5,  0, 32'h0, 1'b0};
`ifdef DMEM_RESP_WSTRB_EN
      vt[10] = '{1'b0, 32'h030, 32'h0,        4'hF,  2, 32'h11BB33DD, 1'b0};
`else
      vt[10] = '{1'b0, 32'h030, 32'h0,        4'hF,  2, 32'hAABBCCDD, 1'b0};
`endif
      vt[11] = '{1'b1, 32'h034, 32'h00000055, 4'hF,  0, 32'h0, 1'b0};
      vt[12] = '{1'b1, 32'h034, 32'hFFFFFFFF, 4'h0,  0, 32'h0, 1'b0};
`ifdef DMEM_RESP_WSTRB_EN
      vt[13] = '{1'b0, 32'h034, 32'h0,        4'hF,  0, 32'h00000055, 1'b0};
`else
      vt[13] = '{1'b0, 32'h034, 32'h0,        4'hF,  0, 32'hFFFFFFFF, 1'b0};
`endif
      vt[14] = '{1'b1, 32'h002, 32'hFFFFFFFF, 4'hF,  0, 32'h0, 1'b1};
      vt[15] = '{1'b0, 32'h000, 32'h0,        4'hF,  0, 32'hCAFEF00D, 1'b0};
      vt[16] = '{1'b0, 32'h010, 32'h0,        4'hF, -1, 32'hDEADBEEF, 1'b0};
      vt[17] = '{1'b1, 32'h020, 32'h00000000, 4'hF,  0, 32'h0, 1'b0};

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'd0;
         req_wdata[i] = 32'd0; req_wstrb[i] = 4'd0; rsp_ready[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      check_reset_outs(0, "reset0");
      check_reset_outs(1, "reset1");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         txn(0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].ws, vt[i].hold, rd, er, lat, acc);
         chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W0 + 1));
      end

      // reset while the store to 0x20 is in its last wait state
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
      req_wdata[0] = 32'h5; req_wstrb[0] = 4'hF; rsp_ready[0] = 1'b0;
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outs(0, "rst_wait");
      rst = 1'b0;
      txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat, acc);
      chk("rst_wait_load", rd, 32'h0);

      // reset while a committed store response is pending
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h24;
      req_wdata[0] = 32'h77; req_wstrb[0] = 4'hF; rsp_ready[0] = 1'b0;
      @(negedge clk);
      req_valid[0] = 1'b0;
      n = 0;
      while (!rsp_valid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_resp_valid_up", 32'(rsp_valid[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outs(0, "rst_resp");
      rst = 1'b0;
      txn(0, 1'b0, 32'h24, 32'h0, 4'hF, 0, rd, er, lat, acc);
      chk("rst_resp_load", rd, 32'h77);

      // fill the model's windows with known data through the DUTs
      for (d = 0; d < 2; d++) begin
         for (int w = 0; w < ((d == 0) ? 32 : 16); w++) begin
            a  = base_of(d) + 32'(4 * w);
            wd = $urandom;
            m_apply(d, 1'b1, a, wd, 4'hF, erd, eerr, ok);
            txn(d, 1'b1, a, wd, 4'hF, 0, rd, er, lat, acc);
            chk("init_err", 32'(er), 32'(eerr));
         end
      end

      // zero-wait back-to-back loads with rsp_ready held high
      prev_acc = 0;
      for (int k = 0; k < 3; k++) begin
         a = B1 + 32'(4 * k);
         m_apply(1, 1'b0, a, 32'h0, 4'hF, erd, eerr, ok);
         txn(1, 1'b0, a, 32'h0, 4'hF, -1, rd, er, lat, acc);
         chk($sformatf("b2b%0d_rdata", k), rd, erd);
         chk($sformatf("b2b%0d_latency", k), 32'(lat), 32'd1);
         if (k > 0) chk($sformatf("b2b%0d_period", k), 32'(acc - prev_acc), 32'd2);
         prev_acc = acc;
      end
      rsp_ready[1] = 1'b0;

      // randomized traffic on both instances
      for (int i = 0; i < 200; i++) begin
         d    = int'($urandom % 2);
         wr   = 1'($urandom);
         a    = gen_addr(d);
         wd   = $urandom;
         ws   = 4'($urandom);
         hold = int'($urandom_range(0, 4)) - 1;
         m_apply(d, wr, a, wd, ws, erd, eerr, ok);
         txn(d, wr, a, wd, ws, hold, rd, er, lat, acc);
         chk($sformatf("rnd%0d_err", i), 32'(er), 32'(eerr));
         if (ok) chk($sformatf("rnd%0d_rdata", i), rd, erd);
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(((d == 0) ? W0 : W1) + 1));
         rsp_ready[d] = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
